// File: rtl/riscv_arb_pkg.sv
// Shared types and default widths for the cache-to-memory arbiter.
//   arb_state_e : arbiter FSM states
//   arb_owner_e : which cache owns (or last owned) the memory port
package riscv_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 64;
    localparam int unsigned LINE_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IC = 2'd1,
        SERVE_DC = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/riscv_cache_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the icache
// (refill only) and the dcache (refill or writeback). One transaction is
// outstanding at a time; every memory-side output and done pulse is registered.
//
// Ports:
//   i_riscv_arb_clk / i_riscv_arb_rst  : clock, async active-high reset
//   i_riscv_arb_ic_*                   : icache request, line address, done pulse
//   i_riscv_arb_dc_*                   : dcache request, we, address, wdata, done pulse
//   o_riscv_arb_rdata                  : refill line, valid with either done pulse
//   o_riscv_arb_mem_*                  : registered request to main memory
//   i_riscv_arb_mem_ready / _rdata     : memory completion pulse and line data
module riscv_cache_mem_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF
) (
    input  logic              i_riscv_arb_clk,
    input  logic              i_riscv_arb_rst,
    input  logic              i_riscv_arb_ic_req,
    input  logic [ADDR_W-1:0] i_riscv_arb_ic_addr,
    output logic              o_riscv_arb_ic_done,
    input  logic              i_riscv_arb_dc_req,
    input  logic              i_riscv_arb_dc_we,
    input  logic [ADDR_W-1:0] i_riscv_arb_dc_addr,
    input  logic [LINE_W-1:0] i_riscv_arb_dc_wdata,
    output logic              o_riscv_arb_dc_done,
    output logic [LINE_W-1:0] o_riscv_arb_rdata,
    output logic              o_riscv_arb_mem_req,
    output logic              o_riscv_arb_mem_we,
    output logic [ADDR_W-1:0] o_riscv_arb_mem_addr,
    output logic [LINE_W-1:0] o_riscv_arb_mem_wdata,
    input  logic              i_riscv_arb_mem_ready,
    input  logic [LINE_W-1:0] i_riscv_arb_mem_rdata
);

    arb_state_e        state_q, state_d;
    arb_owner_e        last_q, last_d;      // most recently served requester
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              ic_done_q, ic_done_d;
    logic              dc_done_q, dc_done_d;
    logic              pick_dc_c;

    // Round-robin pick: dcache wins when alone, or on a tie when icache was served last.
    always_comb begin
        pick_dc_c = i_riscv_arb_dc_req & (~i_riscv_arb_ic_req | (last_q == OWN_IC));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ic_done_d   = 1'b0;
        dc_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // mem_ready is ignored here; only requests matter.
                if (i_riscv_arb_ic_req || i_riscv_arb_dc_req) begin
                    mem_req_d = 1'b1;
                    if (pick_dc_c) begin
                        state_d     = SERVE_DC;
                        mem_we_d    = i_riscv_arb_dc_we;
                        mem_addr_d  = i_riscv_arb_dc_addr;
                        mem_wdata_d = i_riscv_arb_dc_wdata;
                    end else begin
                        state_d     = SERVE_IC;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_riscv_arb_ic_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            SERVE_IC: begin
                // Request inputs are not looked at: the transaction always completes.
                if (i_riscv_arb_mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    ic_done_d = 1'b1;
                    rdata_d   = i_riscv_arb_mem_rdata;
                    last_d    = OWN_IC;
                end
            end
            SERVE_DC: begin
                if (i_riscv_arb_mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    dc_done_d = 1'b1;
                    last_d    = OWN_DC;
                    // Writebacks return no line; keep the previous refill data.
                    if (!mem_we_q) begin
                        rdata_d = i_riscv_arb_mem_rdata;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge i_riscv_arb_clk or posedge i_riscv_arb_rst) begin
        if (i_riscv_arb_rst) begin
            state_q     <= IDLE;
            last_q      <= OWN_IC;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ic_done_q   <= 1'b0;
            dc_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ic_done_q   <= ic_done_d;
            dc_done_q   <= dc_done_d;
        end
    end

    assign o_riscv_arb_ic_done   = ic_done_q;
    assign o_riscv_arb_dc_done   = dc_done_q;
    assign o_riscv_arb_rdata     = rdata_q;
    assign o_riscv_arb_mem_req   = mem_req_q;
    assign o_riscv_arb_mem_we    = mem_we_q;
    assign o_riscv_arb_mem_addr  = mem_addr_q;
    assign o_riscv_arb_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_riscv_cache_mem_arbiter.sv
// Self-checking bench for riscv_cache_mem_arbiter. Inputs are driven and
// outputs sampled on the falling clock edge; expected transactions are
// queued when requests are raised and popped when the done pulse appears.
module tb_riscv_cache_mem_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned LW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_req, dc_req, dc_we, mem_ready;
    logic [AW-1:0] ic_addr, dc_addr;
    logic [LW-1:0] dc_wdata, mem_rdata;
    logic          ic_done, dc_done, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata, rdata;

    always #5 clk = ~clk;

    riscv_cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .i_riscv_arb_clk       (clk),
        .i_riscv_arb_rst       (rst),
        .i_riscv_arb_ic_req    (ic_req),
        .i_riscv_arb_ic_addr   (ic_addr),
        .o_riscv_arb_ic_done   (ic_done),
        .i_riscv_arb_dc_req    (dc_req),
        .i_riscv_arb_dc_we     (dc_we),
        .i_riscv_arb_dc_addr   (dc_addr),
        .i_riscv_arb_dc_wdata  (dc_wdata),
        .o_riscv_arb_dc_done   (dc_done),
        .o_riscv_arb_rdata     (rdata),
        .o_riscv_arb_mem_req   (mem_req),
        .o_riscv_arb_mem_we    (mem_we),
        .o_riscv_arb_mem_addr  (mem_addr),
        .o_riscv_arb_mem_wdata (mem_wdata),
        .i_riscv_arb_mem_ready (mem_ready),
        .i_riscv_arb_mem_rdata (mem_rdata)
    );

    typedef struct {
        logic          own_dc;
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } exp_t;

    exp_t          sbq[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          model_last_dc;   // 1 when dcache was served most recently
    logic [LW-1:0] model_rdata;     // last refill line the arbiter should hold

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic model_pick_dc(input logic ic, input logic dc);
        return dc && (!ic || !model_last_dc);
    endfunction

    task automatic wait_mem_req(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (mem_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ready = 1'b0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
        tick(); tick();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_checks++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        n_checks++; if ({ic_done, dc_done} !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b want 00", {ic_done, dc_done}); end
        n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        rst = 1'b0;
        model_last_dc = 1'b0;
        model_rdata   = '0;
        tick();
    endtask

    task automatic test_ic_refill();
        exp_t e;
        e.own_dc = 1'b0; e.we = 1'b0; e.addr = 64'h8000_0040; e.wdata = '0; e.rdata = {16{8'hA5}};
        sbq.push_back(e);
        ic_addr = e.addr; ic_req = 1'b1;
        tick();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL ic_grant_latency: mem_req got %b want 1", mem_req); end
        n_checks++; if (mem_addr !== sbq[0].addr) begin n_fail++; $display("FAIL ic_mem_addr: got %h want %h", mem_addr, sbq[0].addr); end
        n_checks++; if ({mem_we, mem_wdata} !== {sbq[0].we, sbq[0].wdata}) begin n_fail++; $display("FAIL ic_mem_we_wdata: got %b/%h want 0/0", mem_we, mem_wdata); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== sbq[0].addr) begin n_fail++; $display("FAIL ic_hold_%0d: req %b addr %h want 1 %h", k, mem_req, mem_addr, sbq[0].addr); end
        end
        mem_ready = 1'b1; mem_rdata = sbq[0].rdata;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        e = sbq.pop_front();
        n_checks++; if ({ic_done, dc_done} !== 2'b10) begin n_fail++; $display("FAIL ic_done_pulse: got %b want 10", {ic_done, dc_done}); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL ic_req_drop: got %b want 0", mem_req); end
        n_checks++; if (rdata !== e.rdata) begin n_fail++; $display("FAIL ic_rdata: got %h want %h", rdata, e.rdata); end
        model_last_dc = 1'b0; model_rdata = e.rdata;
        ic_req = 1'b0;
        tick();
        n_checks++; if ({ic_done, mem_req} !== 2'b00) begin n_fail++; $display("FAIL ic_done_one_cycle: done/req got %b want 00", {ic_done, mem_req}); end
    endtask

    task automatic test_round_robin();
        bit   r_ic [3] = '{1'b1, 1'b0, 1'b1};
        bit   r_dc [3] = '{1'b1, 1'b1, 1'b1};
        exp_t e;
        bit   seen;
        bit   first_dc;
        rst = 1'b1; tick(); rst = 1'b0;
        model_last_dc = 1'b0; model_rdata = '0;
        for (int r = 0; r < 3; r++) begin
            ic_addr = 64'h8000_0100 + 64'(r) * 64'h40;
            dc_addr = 64'h8000_0200 + 64'(r) * 64'h40;
            dc_we = 1'b0; dc_wdata = '0;
            first_dc = model_pick_dc(r_ic[r], r_dc[r]);
            for (int s = 0; s < 2; s++) begin
                bit own;
                own = (s == 0) ? first_dc : !first_dc;
                if ((own && r_dc[r]) || (!own && r_ic[r])) begin
                    e.own_dc = own; e.we = 1'b0; e.wdata = '0;
                    e.addr   = own ? dc_addr : ic_addr;
                    e.rdata  = {4{8'(r), 8'(s), 16'hBEEF}};
                    sbq.push_back(e);
                end
            end
            ic_req = r_ic[r]; dc_req = r_dc[r];
            while (sbq.size() > 0) begin
                wait_mem_req(20, seen);
                n_checks++; if (!seen) begin n_fail++; $display("FAIL rr_timeout round %0d: mem_req got %b want 1", r, mem_req); end
                if (!seen) begin
                    sbq.delete();
                    break;
                end
                n_checks++; if (mem_addr !== sbq[0].addr) begin n_fail++; $display("FAIL rr_winner round %0d: addr got %h want %h", r, mem_addr, sbq[0].addr); end
                n_checks++; if ({mem_we, mem_wdata} !== {1'b0, {LW{1'b0}}}) begin n_fail++; $display("FAIL rr_we_wdata round %0d: got %b/%h want 0/0", r, mem_we, mem_wdata); end
                mem_ready = 1'b1; mem_rdata = sbq[0].rdata;
                tick();
                mem_ready = 1'b0; mem_rdata = '0;
                e = sbq.pop_front();
                n_checks++; if ({ic_done, dc_done} !== {!e.own_dc, e.own_dc}) begin n_fail++; $display("FAIL rr_done round %0d: got %b want %b", r, {ic_done, dc_done}, {!e.own_dc, e.own_dc}); end
                n_checks++; if (rdata !== e.rdata || mem_req !== 1'b0) begin n_fail++; $display("FAIL rr_complete round %0d: rdata %h req %b want %h 0", r, rdata, mem_req, e.rdata); end
                model_last_dc = e.own_dc; model_rdata = e.rdata;
                if (e.own_dc) dc_req = 1'b0;
                else          ic_req = 1'b0;
                tick();
                if (sbq.size() > 0) begin
                    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rr_regrant round %0d: mem_req got %b want 1", r, mem_req); end
                end
            end
        end
    endtask

    task automatic test_writeback();
        exp_t e;
        e.own_dc = 1'b1; e.we = 1'b1; e.addr = 64'h8000_1000;
        e.wdata = {8{16'h1234}}; e.rdata = model_rdata;
        sbq.push_back(e);
        dc_we = 1'b1; dc_addr = e.addr; dc_wdata = e.wdata; dc_req = 1'b1;
        tick();
        n_checks++; if ({mem_req, mem_we} !== 2'b11) begin n_fail++; $display("FAIL wb_req_we: got %b want 11", {mem_req, mem_we}); end
        n_checks++; if (mem_wdata !== sbq[0].wdata || mem_addr !== sbq[0].addr) begin n_fail++; $display("FAIL wb_payload: %h@%h want %h@%h", mem_wdata, mem_addr, sbq[0].wdata, sbq[0].addr); end
        mem_ready = 1'b1; mem_rdata = {4{32'hDEAD_BEEF}};
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        e = sbq.pop_front();
        n_checks++; if ({ic_done, dc_done} !== 2'b01) begin n_fail++; $display("FAIL wb_done: got %b want 01", {ic_done, dc_done}); end
        n_checks++; if (rdata !== e.rdata) begin n_fail++; $display("FAIL wb_rdata_hold: got %h want %h", rdata, e.rdata); end
        model_last_dc = 1'b1;
        dc_req = 1'b0; dc_we = 1'b0; dc_wdata = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [LW-1:0] line;
        line = {2{64'h0BAD_F00D_CAFE_0001}};
        dc_we = 1'b0; dc_addr = 64'h8000_2000; dc_req = 1'b1;
        tick();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rm_grant: mem_req got %b want 1", mem_req); end
        tick(); tick();
        rst = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rm_async_drop: mem_req got %b want 0", mem_req); end
        n_checks++; if ({dc_done, rdata} !== {1'b0, {LW{1'b0}}}) begin n_fail++; $display("FAIL rm_reset_state: done %b rdata %h want 0 0", dc_done, rdata); end
        model_last_dc = 1'b0; model_rdata = '0;
        tick();
        n_checks++; if (dc_done !== 1'b0) begin n_fail++; $display("FAIL rm_no_done: got %b want 0", dc_done); end
        rst = 1'b0;
        tick();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== dc_addr) begin n_fail++; $display("FAIL rm_regrant: req %b addr %h want 1 %h", mem_req, mem_addr, dc_addr); end
        mem_ready = 1'b1; mem_rdata = line;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        n_checks++; if ({dc_done, rdata} !== {1'b1, line}) begin n_fail++; $display("FAIL rm_complete: done %b rdata %h want 1 %h", dc_done, rdata, line); end
        model_last_dc = 1'b1; model_rdata = line;
        dc_req = 1'b0;
        tick();
    endtask

    task automatic test_ready_idle_and_drop();
        logic [LW-1:0] line;
        line = {4{32'h5A5A_0F0F}};
        mem_ready = 1'b1; mem_rdata = {4{32'hFFFF_0000}};
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        n_checks++; if ({ic_done, dc_done, mem_req} !== 3'b000) begin n_fail++; $display("FAIL idle_ready: done/req got %b want 000", {ic_done, dc_done, mem_req}); end
        n_checks++; if (rdata !== model_rdata) begin n_fail++; $display("FAIL idle_rdata: got %h want %h", rdata, model_rdata); end
        dc_we = 1'b0; dc_addr = 64'h8000_3000; dc_req = 1'b1;
        tick();
        dc_req = 1'b0;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL drop_grant: mem_req got %b want 1", mem_req); end
        tick();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL drop_hold: mem_req got %b want 1", mem_req); end
        mem_ready = 1'b1; mem_rdata = line;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        n_checks++; if ({dc_done, rdata} !== {1'b1, line}) begin n_fail++; $display("FAIL drop_done: done %b rdata %h want 1 %h", dc_done, rdata, line); end
        model_last_dc = 1'b1; model_rdata = line;
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int t = 0; t < 2; t++) begin
            e.own_dc = 1'b0; e.we = 1'b0; e.wdata = '0;
            e.addr = 64'h8000_4000 + 64'(t) * 64'h40;
            e.rdata = {4{32'h7700_0000 + 32'(t)}};
            sbq.push_back(e);
        end
        ic_addr = sbq[0].addr; ic_req = 1'b1;
        tick();
        for (int t = 0; t < 2; t++) begin
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== sbq[0].addr) begin n_fail++; $display("FAIL b2b_grant_%0d: req %b addr %h want 1 %h", t, mem_req, mem_addr, sbq[0].addr); end
            mem_ready = 1'b1; mem_rdata = sbq[0].rdata;
            tick();
            mem_ready = 1'b0; mem_rdata = '0;
            e = sbq.pop_front();
            n_checks++; if ({ic_done, mem_req, rdata} !== {2'b10, e.rdata}) begin n_fail++; $display("FAIL b2b_done_%0d: done %b req %b rdata %h want 1 0 %h", t, ic_done, mem_req, rdata, e.rdata); end
            model_last_dc = 1'b0; model_rdata = e.rdata;
            if (sbq.size() > 0) ic_addr = sbq[0].addr;
            else                ic_req  = 1'b0;
            tick();
        end
        n_checks++; if ({ic_done, mem_req} !== 2'b00) begin n_fail++; $display("FAIL b2b_quiet: done/req got %b want 00", {ic_done, mem_req}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ic_refill();
        test_round_robin();
        test_writeback();
        test_reset_mid();
        test_ready_idle_and_drop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
